// File: rtl/sd_perf_pkg.sv
// sd_perf_pkg: shared types and constants for the SD-SPI performance reader.
//   state_t       - reader FSM states
//   BLOCK_BYTES   - SD block size in bytes
//   BYTE_CNT_W    - width of the byte-in-block counter
//   *_SIZE_DEF    - default port widths shared with the autotest FSM
package sd_perf_pkg;

    localparam int unsigned BLOCK_BYTES          = 512;
    localparam int unsigned BYTE_CNT_W           = 9;
    localparam int unsigned N_BLOCK_SIZE_DEF     = 32;
    localparam int unsigned SCLK_SPEED_SIZE_DEF  = 8;
    localparam int unsigned CMD18_SIZE_DEF       = 8;

    typedef enum logic [3:0] {
        IDLE,
        RST_SPI,
        WAIT_RST,
        SEL_BLOCK,
        WAIT_BLOCK,
        REQ_BYTE,
        WAIT_BYTE,
        END_BLOCK,
        STOP,
        DRAIN,
        DONE
    } state_t;

    // A run is in progress (host may be driven); IDLE and DONE are at rest.
    function automatic logic is_active(input state_t s);
        return !(s inside {IDLE, DONE});
    endfunction

endpackage

// File: rtl/counter.sv
// counter: loadable up/down counter with synchronous active-high reset.
//   clk, rst     - clock, synchronous reset (to ResetVal)
//   load_i       - load load_val_i (has priority over en_i)
//   en_i, down_i - count enable and direction (1 = decrement)
//   value_o      - current count; wraps modulo 2^Width
module counter #(
    parameter int unsigned     Width    = 8,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    input  logic             down_i,
    output logic [Width-1:0] value_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = down_i ? count_q - Width'(1) : count_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= ResetVal;
        end else begin
            count_q <= count_d;
        end
    end

    assign value_o = count_q;

endmodule

// File: rtl/sd_perf_reader.sv
// sd_perf_reader: reinitialises the SD-SPI host at a chosen SCLK setting, then reads
// n_blocks 512-byte blocks from START_BLOCK using single-block reads or one multi-block read.
//   clk, rst               - clock, synchronous active-high reset
//   start                  - level, held for the whole run by the autotest
//   n_blocks/sclk_speed/cmd18 - run parameters, latched on start
//   finish                 - run complete (held until start drops)
//   err, crc_err           - sticky host error flags for the run
//   checksum, bytes_read   - byte sum (mod 2^32) and saturating byte count
//   spi_busy/err/crc_err, spi_data_out - host status and read data
//   spi_rst, spi_r_block, spi_r_byte, spi_r_multi_block - host requests
//   spi_block_addr, spi_sclk_speed - block address and latched SCLK code
module sd_perf_reader
    import sd_perf_pkg::*;
#(
    parameter int unsigned N_BLOCK_SIZE    = N_BLOCK_SIZE_DEF,  // multiple of 8
    parameter int unsigned SCLK_SPEED_SIZE = SCLK_SPEED_SIZE_DEF,
    parameter int unsigned CMD18_SIZE      = CMD18_SIZE_DEF,
    parameter logic [31:0] START_BLOCK     = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_BLOCK_SIZE-1:0]    n_blocks,
    input  logic [SCLK_SPEED_SIZE-1:0] sclk_speed,
    input  logic [CMD18_SIZE-1:0]      cmd18,
    output logic                       finish,
    output logic                       err,
    output logic                       crc_err,
    output logic [31:0]                checksum,
    output logic [31:0]                bytes_read,
    input  logic                       spi_busy,
    input  logic                       spi_err,
    input  logic                       spi_crc_err,
    input  logic [7:0]                 spi_data_out,
    output logic                       spi_rst,
    output logic                       spi_r_block,
    output logic                       spi_r_byte,
    output logic                       spi_r_multi_block,
    output logic [31:0]                spi_block_addr,
    output logic [SCLK_SPEED_SIZE-1:0] spi_sclk_speed
);

    state_t state_q, state_d;

    logic                       mode_q, mode_d;    // 1 = multi-block (CMD18)
    logic                       abort_q, abort_d;  // DRAIN exits to IDLE instead of DONE
    logic [SCLK_SPEED_SIZE-1:0] sclk_q, sclk_d;
    logic [31:0]                checksum_q, checksum_d;
    logic [31:0]                bytes_read_q, bytes_read_d;
    logic                       err_q, err_d;
    logic                       crc_err_q, crc_err_d;
    logic                       finish_q, finish_d;

    // Counter strobes
    logic run_load;
    logic addr_inc;
    logic blk_dec;
    logic byte_inc;

    logic [N_BLOCK_SIZE-1:0] blk_left;
    logic [BYTE_CNT_W-1:0]   byte_cnt;

    logic capture;
    logic last_byte;
    logic more_blocks;
    logic hw_err;

    assign capture     = (state_q == WAIT_BYTE) && !spi_busy;
    assign last_byte   = (byte_cnt == BYTE_CNT_W'(BLOCK_BYTES - 1));
    assign more_blocks = (blk_left > N_BLOCK_SIZE'(1));
    assign hw_err      = spi_err || spi_crc_err;

    counter #(
        .Width    (32),
        .ResetVal (START_BLOCK)
    ) u_addr_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (run_load),
        .load_val_i (START_BLOCK),
        .en_i       (addr_inc),
        .down_i     (1'b0),
        .value_o    (spi_block_addr)
    );

    counter #(
        .Width    (N_BLOCK_SIZE),
        .ResetVal ('0)
    ) u_blk_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (run_load),
        .load_val_i (n_blocks),
        .en_i       (blk_dec),
        .down_i     (1'b1),
        .value_o    (blk_left)
    );

    // 9-bit byte-in-block counter wraps to 0 naturally after the last byte of a block.
    counter #(
        .Width    (BYTE_CNT_W),
        .ResetVal ('0)
    ) u_byte_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (run_load),
        .load_val_i ('0),
        .en_i       (byte_inc),
        .down_i     (1'b0),
        .value_o    (byte_cnt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and counter strobes
    always_comb begin
        state_d  = state_q;
        abort_d  = abort_q;
        run_load = 1'b0;
        addr_inc = 1'b0;
        blk_dec  = 1'b0;
        byte_inc = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !finish_q) begin
                    run_load = 1'b1;
                    abort_d  = 1'b0;
                    state_d  = (n_blocks == '0) ? DONE : RST_SPI;
                end
            end
            RST_SPI:    if (spi_busy)  state_d = WAIT_RST;
            WAIT_RST:   if (!spi_busy) state_d = SEL_BLOCK;
            SEL_BLOCK:  if (spi_busy)  state_d = WAIT_BLOCK;
            WAIT_BLOCK: if (!spi_busy) state_d = REQ_BYTE;
            REQ_BYTE:   if (spi_busy)  state_d = WAIT_BYTE;
            WAIT_BYTE: begin
                if (!spi_busy) begin
                    byte_inc = 1'b1;
                    if (!last_byte) begin
                        state_d = REQ_BYTE;
                    end else if (mode_q) begin
                        // Address advances on every block end so it finishes at
                        // START_BLOCK + n_blocks, matching single-block mode.
                        addr_inc = 1'b1;
                        blk_dec  = 1'b1;
                        state_d  = more_blocks ? REQ_BYTE : STOP;
                    end else begin
                        state_d = END_BLOCK;
                    end
                end
            end
            END_BLOCK: begin
                if (!spi_busy) begin
                    addr_inc = 1'b1;
                    blk_dec  = 1'b1;
                    state_d  = more_blocks ? SEL_BLOCK : DONE;
                end
            end
            STOP:  if (!spi_busy) state_d = DONE;
            DRAIN: if (!spi_busy) state_d = abort_q ? IDLE : DONE;
            DONE:  if (!start)    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Error or abort overrides the normal flow; a byte captured this cycle still counts.
        if (is_active(state_q)) begin
            if (!start) begin
                abort_d = 1'b1;
            end
            if (state_q != DRAIN && (hw_err || !start)) begin
                state_d = DRAIN;
            end
        end
    end

    // Datapath registers
    always_comb begin
        mode_d       = mode_q;
        sclk_d       = sclk_q;
        checksum_d   = checksum_q;
        bytes_read_d = bytes_read_q;
        err_d        = err_q;
        crc_err_d    = crc_err_q;
        finish_d     = (state_q == DONE);

        if (run_load) begin
            mode_d       = (cmd18 != '0);
            sclk_d       = sclk_speed;
            checksum_d   = '0;
            bytes_read_d = '0;
            err_d        = 1'b0;
            crc_err_d    = 1'b0;
        end

        if (capture) begin
            checksum_d   = checksum_q + 32'(spi_data_out);
            bytes_read_d = (bytes_read_q == '1) ? bytes_read_q : bytes_read_q + 32'd1;
        end

        if (is_active(state_q)) begin
            if (spi_err)     err_d     = 1'b1;
            if (spi_crc_err) crc_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= 1'b0;
            abort_q      <= 1'b0;
            sclk_q       <= '0;
            checksum_q   <= '0;
            bytes_read_q <= '0;
            err_q        <= 1'b0;
            crc_err_q    <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            abort_q      <= abort_d;
            sclk_q       <= sclk_d;
            checksum_q   <= checksum_d;
            bytes_read_q <= bytes_read_d;
            err_q        <= err_d;
            crc_err_q    <= crc_err_d;
            finish_q     <= finish_d;
        end
    end

    // Output decode: registered state only, never combinational on spi_busy.
    logic block_hold;

    always_comb begin
        block_hold        = state_q inside {SEL_BLOCK, WAIT_BLOCK, REQ_BYTE, WAIT_BYTE};
        spi_rst           = (state_q == RST_SPI);
        spi_r_byte        = (state_q == REQ_BYTE);
        spi_r_block       = block_hold && !mode_q;
        spi_r_multi_block = block_hold && mode_q;
    end

    assign finish         = finish_q;
    assign err            = err_q;
    assign crc_err        = crc_err_q;
    assign checksum       = checksum_q;
    assign bytes_read     = bytes_read_q;
    assign spi_sclk_speed = sclk_q;

endmodule

// File: tb/tb_sd_perf_reader.sv
// Directed bench for sd_perf_reader with a simple SD-SPI host responder.
module tb_sd_perf_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] n_blocks = '0;
    logic [7:0]  sclk_speed = '0;
    logic [7:0]  cmd18 = '0;
    logic        finish, err, crc_err;
    logic [31:0] checksum, bytes_read;
    logic        spi_busy = 1'b0;
    logic        spi_err = 1'b0;
    logic        spi_crc_err = 1'b0;
    logic [7:0]  spi_data_out = '0;
    logic        spi_rst, spi_r_block, spi_r_byte, spi_r_multi_block;
    logic [31:0] spi_block_addr;
    logic [7:0]  spi_sclk_speed;

    always #5 clk = ~clk;

    sd_perf_reader dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .n_blocks          (n_blocks),
        .sclk_speed        (sclk_speed),
        .cmd18             (cmd18),
        .finish            (finish),
        .err               (err),
        .crc_err           (crc_err),
        .checksum          (checksum),
        .bytes_read        (bytes_read),
        .spi_busy          (spi_busy),
        .spi_err           (spi_err),
        .spi_crc_err       (spi_crc_err),
        .spi_data_out      (spi_data_out),
        .spi_rst           (spi_rst),
        .spi_r_block       (spi_r_block),
        .spi_r_byte        (spi_r_byte),
        .spi_r_multi_block (spi_r_multi_block),
        .spi_block_addr    (spi_block_addr),
        .spi_sclk_speed    (spi_sclk_speed)
    );

    int checks = 0;
    int errors = 0;

    // Host responder: each request keeps busy high for 2 cycles; bytes are byte_idx mod 256.
    logic        host_clr = 1'b0;
    int          inject_at = -1;
    int          host_cnt = 0;
    logic        host_byte = 1'b0;
    int          byte_idx = 0;
    logic        blk_prev = 1'b0;
    logic        multi_prev = 1'b0;
    int          blk_starts = 0;
    int          multi_starts = 0;
    int          multi_bytes = 0;
    logic        finish_seen = 1'b0;
    logic [31:0] blk_addr_log [4];

    always @(negedge clk) begin
        if (host_clr) begin
            host_cnt     = 0;
            spi_busy     = 1'b0;
            spi_crc_err  = 1'b0;
            spi_data_out = '0;
            byte_idx     = 0;
            blk_starts   = 0;
            multi_starts = 0;
            multi_bytes  = 0;
            blk_prev     = 1'b0;
            multi_prev   = 1'b0;
            finish_seen  = 1'b0;
        end else begin
            spi_crc_err = 1'b0;
            if (host_cnt > 0) begin
                host_cnt--;
                if (host_cnt == 0) begin
                    spi_busy = 1'b0;
                    if (host_byte) begin
                        spi_data_out = 8'(byte_idx);
                        if (byte_idx == inject_at) spi_crc_err = 1'b1;
                        if (spi_r_multi_block) multi_bytes++;
                        byte_idx++;
                    end
                end
            end else if (spi_rst || spi_r_byte) begin
                spi_busy  = 1'b1;
                host_cnt  = 2;
                host_byte = spi_r_byte;
            end else if (spi_r_block && !blk_prev) begin
                if (blk_starts < 4) blk_addr_log[blk_starts] = spi_block_addr;
                blk_starts++;
                spi_busy  = 1'b1;
                host_cnt  = 2;
                host_byte = 1'b0;
            end else if (spi_r_multi_block && !multi_prev) begin
                multi_starts++;
                spi_busy  = 1'b1;
                host_cnt  = 2;
                host_byte = 1'b0;
            end
            blk_prev   = spi_r_block;
            multi_prev = spi_r_multi_block;
            if (finish) finish_seen = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_host();
        host_clr = 1'b1;
        tick();
        host_clr = 1'b0;
    endtask

    task automatic wait_finish(input string tag, input int bound);
        int n = 0;
        while (!finish && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(finish), 32'd1);
    endtask

    task automatic end_run();
        start = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_finish", 32'(finish), 32'd0);
        check("rst_bytes", bytes_read, 32'd0);
        check("rst_checksum", checksum, 32'd0);
        check("rst_addr", spi_block_addr, 32'd0);
        check("rst_reqs", {28'd0, spi_rst, spi_r_block, spi_r_byte, spi_r_multi_block}, 32'd0);
        rst = 1'b0;
        tick();

        // n_blocks = 0: no host reset, finish two cycles after start
        clear_host();
        n_blocks = 32'd0;
        cmd18    = 8'd0;
        start    = 1'b1;
        tick();
        check("n0_no_spi_rst", 32'(spi_rst), 32'd0);
        check("n0_finish_c1", 32'(finish), 32'd0);
        tick();
        check("n0_finish_c2", 32'(finish), 32'd1);
        check("n0_bytes", bytes_read, 32'd0);
        start = 1'b0;
        tick();
        tick();
        check("n0_finish_drop", 32'(finish), 32'd0);
        tick();

        // Two single-block reads
        clear_host();
        n_blocks   = 32'd2;
        cmd18      = 8'd0;
        sclk_speed = 8'h05;
        start      = 1'b1;
        tick();
        check("s2_spi_rst_latency", 32'(spi_rst), 32'd1);
        check("s2_sclk", 32'(spi_sclk_speed), 32'h05);
        wait_finish("s2_finish", 20000);
        check("s2_bytes", bytes_read, 32'd1024);
        check("s2_checksum", checksum, 32'd130560);
        check("s2_blk_starts", 32'(blk_starts), 32'd2);
        check("s2_addr0", blk_addr_log[0], 32'd0);
        check("s2_addr1", blk_addr_log[1], 32'd1);
        check("s2_addr_end", spi_block_addr, 32'd2);
        check("s2_flags", {30'd0, err, crc_err}, 32'd0);
        end_run();

        // One CMD18 multi-block read of three blocks
        clear_host();
        n_blocks = 32'd3;
        cmd18    = 8'd1;
        start    = 1'b1;
        wait_finish("m3_finish", 30000);
        check("m3_multi_starts", 32'(multi_starts), 32'd1);
        check("m3_multi_bytes", 32'(multi_bytes), 32'd1536);
        check("m3_single_starts", 32'(blk_starts), 32'd0);
        check("m3_addr_end", spi_block_addr, 32'd3);
        check("m3_bytes", bytes_read, 32'd1536);
        check("m3_checksum", checksum, 32'd195840);
        end_run();

        // CRC error on byte 100 of block 0
        clear_host();
        inject_at = 100;
        n_blocks  = 32'd2;
        cmd18     = 8'd0;
        start     = 1'b1;
        wait_finish("crc_finish", 5000);
        check("crc_flag", 32'(crc_err), 32'd1);
        check("crc_err_flag", 32'(err), 32'd0);
        check("crc_bytes", bytes_read, 32'd101);
        check("crc_checksum", checksum, 32'd5050);
        check("crc_reqs_drop", {30'd0, spi_r_block, spi_r_byte}, 32'd0);
        inject_at = -1;
        end_run();

        // Abort mid-block 1, then restart
        clear_host();
        n_blocks = 32'd2;
        cmd18    = 8'd0;
        start    = 1'b1;
        for (int i = 0; i < 10000 && byte_idx < 600; i++) tick();
        check("abort_reached_blk1", 32'(byte_idx >= 600), 32'd1);
        start = 1'b0;
        repeat (20) tick();
        check("abort_no_finish", 32'(finish_seen), 32'd0);
        check("abort_reqs_drop", {29'd0, spi_r_block, spi_r_byte, spi_rst}, 32'd0);
        clear_host();
        n_blocks = 32'd1;
        start    = 1'b1;
        tick();
        check("restart_spi_rst", 32'(spi_rst), 32'd1);
        check("restart_bytes", bytes_read, 32'd0);
        check("restart_checksum", checksum, 32'd0);
        check("restart_addr", spi_block_addr, 32'd0);
        wait_finish("restart_finish", 10000);
        check("restart_bytes_end", bytes_read, 32'd512);
        check("restart_checksum_end", checksum, 32'd65280);
        end_run();

        // Reset while waiting for a byte
        clear_host();
        n_blocks = 32'd1;
        start    = 1'b1;
        for (int i = 0; i < 5000 && !(byte_idx >= 10 && spi_busy && host_byte); i++) tick();
        check("rst_wb_reached", 32'(spi_busy && host_byte), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_wb_finish", 32'(finish), 32'd0);
        check("rst_wb_bytes", bytes_read, 32'd0);
        check("rst_wb_checksum", checksum, 32'd0);
        check("rst_wb_reqs", {28'd0, spi_rst, spi_r_block, spi_r_byte, spi_r_multi_block},
              32'd0);
        check("rst_wb_addr", spi_block_addr, 32'd0);
        check("rst_wb_sclk", 32'(spi_sclk_speed), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
